// File: rtl/frame_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bep_pkg
//  Description : Shared types and defaults for the thermostat frame scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package bep_pkg;

    localparam int c_frame_bits = 192;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECEIVE = 2'd1,
        ST_CHECK   = 2'd2,
        ST_COMMIT  = 2'd3
    } fsm_state_t;

    typedef enum logic [1:0] {
        FIELD_ROOM_TEMP = 2'd0,
        FIELD_SET_TEMP  = 2'd1,
        FIELD_STATE     = 2'd2,
        FIELD_THERMO_ID = 2'd3
    } display_field_t;

endpackage
`default_nettype wire

// File: rtl/frame_scheduler_display_rotator.sv
`default_nettype none
// ============================================================================
//  Module      : display_rotator
//  Description : Cycles the committed fields onto the display every dwell period.
//  Revision    : 1.0 - initial release
// ============================================================================
module display_rotator
    import bep_pkg::*;
#(
    parameter int DWELL_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    input  logic             i_load,
    input  logic [3:0][15:0] i_fields,
    output logic [1:0]       o_field,
    output logic [15:0]      o_value,
    output logic             o_strobe
);

    localparam int c_dwell_w = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [c_dwell_w-1:0] c_dwell_last = c_dwell_w'(DWELL_CYCLES - 1);

    logic [c_dwell_w-1:0] r_dwell;
    logic [1:0]           r_index;
    logic [15:0]          r_value;
    logic                 r_strobe;
    logic                 w_dwell_done;
    logic [1:0]           w_next_index;

    always_comb begin
        w_dwell_done = i_enable && (r_dwell == c_dwell_last);
        w_next_index = i_load ? 2'(FIELD_ROOM_TEMP) : r_index + 2'd1;
    end

    // A load (commit) overrides a coincident dwell expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dwell  <= '0;
            r_index  <= '0;
            r_value  <= '0;
            r_strobe <= 1'b0;
        end else if (i_load || w_dwell_done) begin
            r_dwell  <= '0;
            r_index  <= w_next_index;
            r_value  <= i_fields[w_next_index];
            r_strobe <= 1'b1;
        end else begin
            r_strobe <= 1'b0;
            if (i_enable) begin
                r_dwell <= r_dwell + c_dwell_w'(1);
            end
        end
    end

    assign o_field  = r_index;
    assign o_value  = r_value;
    assign o_strobe = r_strobe;

endmodule
`default_nettype wire

// File: rtl/frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : frame_scheduler
//  Description : Validates decoded thermostat frames, buffers them, drives display.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_scheduler
    import bep_pkg::*;
#(
    parameter int          FRAME_BITS     = c_frame_bits,
    parameter int          TIMEOUT_CYCLES = 4096,
    parameter int          DWELL_CYCLES   = 1000000,
    parameter logic [31:0] PREAMBLE_VALUE = 32'hFFFF_FFFF,
    parameter logic [31:0] CONSTANT_VALUE = 32'hFFFF_FFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        transmission_begin,
    input  logic        bit_valid,
    input  logic [31:0] preamble,
    input  logic [31:0] constant,
    input  logic [31:0] thermostat_id,
    input  logic [15:0] room_temp,
    input  logic [15:0] set_temp,
    input  logic [7:0]  state,
    output logic        frame_valid,
    output logic        frame_error,
    output logic [7:0]  error_count,
    output logic [1:0]  display_field,
    output logic [15:0] display_value,
    output logic        display_strobe,
    output logic        busy
);

    localparam int c_bit_w = $clog2(FRAME_BITS + 1);
    localparam int c_tmo_w = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_bit_w-1:0] c_bits_full = c_bit_w'(FRAME_BITS);
    localparam logic [c_tmo_w-1:0] c_tmo_limit = c_tmo_w'(TIMEOUT_CYCLES);

    fsm_state_t       r_state;
    fsm_state_t       w_next_state;
    logic [c_bit_w-1:0] r_bit_count;
    logic [c_tmo_w-1:0] r_timeout;
    logic [31:0]      r_shadow_id;
    logic [15:0]      r_shadow_room;
    logic [15:0]      r_shadow_set;
    logic [7:0]       r_shadow_state;
    logic             r_frame_valid;
    logic             r_frame_error;
    logic [7:0]       r_error_count;
    logic             w_full;
    logic             w_timed_out;
    logic             w_match;
    logic             w_busy;
    logic             w_commit;
    logic             w_error;
    logic [3:0][15:0] w_fields;
    logic             w_unused_id_hi;

    assign w_full         = (r_bit_count == c_bits_full);
    assign w_timed_out    = (r_timeout == c_tmo_limit);
    assign w_match        = (preamble == PREAMBLE_VALUE) && (constant == CONSTANT_VALUE);
    assign w_unused_id_hi = ^r_shadow_id[31:16];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A new transmission_begin restarts reception from any state.
    always_comb begin
        w_next_state = r_state;
        if (transmission_begin) begin
            w_next_state = ST_RECEIVE;
        end else begin
            case (r_state)
                ST_IDLE:    w_next_state = ST_IDLE;
                ST_RECEIVE: begin
                    if (w_full) begin
                        w_next_state = ST_CHECK;
                    end else if (w_timed_out) begin
                        w_next_state = ST_IDLE;
                    end
                end
                ST_CHECK:   w_next_state = w_match ? ST_COMMIT : ST_IDLE;
                ST_COMMIT:  w_next_state = ST_IDLE;
                default:    w_next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_busy   = (r_state != ST_IDLE);
        w_commit = (r_state == ST_COMMIT) && !transmission_begin;
        w_error  = !transmission_begin &&
                   (((r_state == ST_RECEIVE) && !w_full && w_timed_out) ||
                    ((r_state == ST_CHECK) && !w_match));
    end

    always_ff @(posedge clock) begin
        if (reset || transmission_begin) begin
            r_bit_count <= '0;
            r_timeout   <= '0;
        end else if (r_state == ST_RECEIVE) begin
            if (bit_valid) begin
                r_timeout <= '0;
                if (!w_full) begin
                    r_bit_count <= r_bit_count + c_bit_w'(1);
                end
            end else if (!w_timed_out) begin
                r_timeout <= r_timeout + c_tmo_w'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_shadow_id    <= '0;
            r_shadow_room  <= '0;
            r_shadow_set   <= '0;
            r_shadow_state <= '0;
            r_frame_valid  <= 1'b0;
            r_frame_error  <= 1'b0;
            r_error_count  <= '0;
        end else begin
            r_frame_error <= w_error;
            if (w_error && (r_error_count != 8'hFF)) begin
                r_error_count <= r_error_count + 8'd1;
            end
            if (w_commit) begin
                r_shadow_id    <= thermostat_id;
                r_shadow_room  <= room_temp;
                r_shadow_set   <= set_temp;
                r_shadow_state <= state;
                r_frame_valid  <= 1'b1;
            end
        end
    end

    // The rotator loads on commit, so feed it the values being committed.
    always_comb begin
        if (w_commit) begin
            w_fields[FIELD_ROOM_TEMP] = room_temp;
            w_fields[FIELD_SET_TEMP]  = set_temp;
            w_fields[FIELD_STATE]     = {8'h00, state};
            w_fields[FIELD_THERMO_ID] = thermostat_id[15:0];
        end else begin
            w_fields[FIELD_ROOM_TEMP] = r_shadow_room;
            w_fields[FIELD_SET_TEMP]  = r_shadow_set;
            w_fields[FIELD_STATE]     = {8'h00, r_shadow_state};
            w_fields[FIELD_THERMO_ID] = r_shadow_id[15:0];
        end
    end

    display_rotator #(
        .DWELL_CYCLES (DWELL_CYCLES)
    ) u_display_rotator (
        .clk      (clock),
        .rst      (reset),
        .i_enable (r_frame_valid),
        .i_load   (w_commit),
        .i_fields (w_fields),
        .o_field  (display_field),
        .o_value  (display_value),
        .o_strobe (display_strobe)
    );

    assign frame_valid = r_frame_valid;
    assign frame_error = r_frame_error;
    assign error_count = r_error_count;
    assign busy        = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_scheduler
//  Description : Scoreboard bench for frame_scheduler (commits, errors, rotation).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_scheduler;

    localparam int c_dwell   = 8;
    localparam int c_timeout = 16;

    typedef logic [3:0][15:0] fields_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        transmission_begin = 1'b0;
    logic        bit_valid = 1'b0;
    logic [31:0] preamble = '0;
    logic [31:0] constant = '0;
    logic [31:0] thermostat_id = '0;
    logic [15:0] room_temp = '0;
    logic [15:0] set_temp = '0;
    logic [7:0]  state = '0;
    logic        frame_valid;
    logic        frame_error;
    logic [7:0]  error_count;
    logic [1:0]  display_field;
    logic [15:0] display_value;
    logic        display_strobe;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    fields_t commit_q[$];
    int      err_q[$];

    fields_t m_fields;
    logic    m_valid = 1'b0;
    logic [1:0] m_field = '0;
    int      m_last = 0;
    int      m_rot = 0;

    frame_scheduler #(
        .FRAME_BITS     (192),
        .TIMEOUT_CYCLES (c_timeout),
        .DWELL_CYCLES   (c_dwell),
        .PREAMBLE_VALUE (32'hFFFF_FFFF),
        .CONSTANT_VALUE (32'hFFFF_FFFF)
    ) dut (
        .clock              (clk),
        .reset              (reset),
        .transmission_begin (transmission_begin),
        .bit_valid          (bit_valid),
        .preamble           (preamble),
        .constant           (constant),
        .thermostat_id      (thermostat_id),
        .room_temp          (room_temp),
        .set_temp           (set_temp),
        .state              (state),
        .frame_valid        (frame_valid),
        .frame_error        (frame_error),
        .error_count        (error_count),
        .display_field      (display_field),
        .display_value      (display_value),
        .display_strobe     (display_strobe),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: errors and commit strobes are popped from the queues; any other
    // strobe must be the next rotation step of the last committed buffer.
    always @(negedge clk) begin
        if (reset) begin
            m_valid = 1'b0;
        end else begin
            if (frame_error) begin
                n_tests++;
                if (err_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_error: frame_error with error_count=%0d, required no error", error_count);
                end else begin
                    int e;
                    e = err_q.pop_front();
                    if (error_count !== 8'(e)) begin
                        n_fail++;
                        $display("FAIL error_count: got %0d, required %0d", error_count, e);
                    end
                end
            end
            if (display_strobe) begin
                n_tests++;
                if (commit_q.size() > 0 && display_field == 2'd0 &&
                    display_value == commit_q[0][0] && frame_valid === 1'b1) begin
                    m_fields = commit_q.pop_front();
                    m_valid  = 1'b1;
                    m_field  = 2'd0;
                    m_last   = cyc;
                end else if (!m_valid) begin
                    n_fail++;
                    $display("FAIL unexpected_strobe: field=%0d value=%h frame_valid=%b, required no strobe",
                             display_field, display_value, frame_valid);
                end else begin
                    logic [1:0] nf;
                    nf = m_field + 2'd1;
                    if (display_field !== nf || display_value !== m_fields[nf] ||
                        (cyc - m_last) != c_dwell || frame_valid !== 1'b1) begin
                        n_fail++;
                        $display("FAIL rotation: field=%0d value=%h interval=%0d, required field=%0d value=%h interval=%0d",
                                 display_field, display_value, cyc - m_last, nf, m_fields[nf], c_dwell);
                    end
                    m_field = nf;
                    m_last  = cyc;
                    m_rot++;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic drain(input int budget, input string tag);
        int k = 0;
        while ((commit_q.size() != 0 || err_q.size() != 0) && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        n_tests++;
        if (commit_q.size() != 0 || err_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: pending commits=%0d errors=%0d, required 0",
                     tag, commit_q.size(), err_q.size());
            commit_q.delete();
            err_q.delete();
        end
    endtask

    task automatic send_frame(input int nbits, input logic [31:0] pre, input logic [31:0] con,
                              input logic [31:0] id, input logic [15:0] rt,
                              input logic [15:0] stp, input logic [7:0] sb);
        @(posedge clk);
        #1;
        preamble = pre; constant = con; thermostat_id = id;
        room_temp = rt; set_temp = stp; state = sb;
        transmission_begin = 1'b1;
        @(posedge clk);
        #1;
        transmission_begin = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            bit_valid = 1'b1;
            @(posedge clk);
            #1;
            bit_valid = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_frame_valid"},    32'(frame_valid),    32'h0);
        check({tag, "_frame_error"},    32'(frame_error),    32'h0);
        check({tag, "_error_count"},    32'(error_count),    32'h0);
        check({tag, "_display_field"},  32'(display_field),  32'h0);
        check({tag, "_display_value"},  32'(display_value),  32'h0);
        check({tag, "_display_strobe"}, 32'(display_strobe), 32'h0);
        check({tag, "_busy"},           32'(busy),           32'h0);
    endtask

    initial begin
        fields_t f;
        int base;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        #1;
        reset = 1'b0;

        // Good frame: commit shows room_temp first, then rotates 1,2,3,0.
        f[0] = 16'h00D2; f[1] = 16'h00E6; f[2] = 16'h0005; f[3] = 16'h1234;
        commit_q.push_back(f);
        send_frame(100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hCAFE_1234, 16'h00D2, 16'h00E6, 8'h05);
        check("busy_receiving", 32'(busy), 32'h1);
        send_frame(192, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hCAFE_1234, 16'h00D2, 16'h00E6, 8'h05);
        drain(40, "commit1");
        base = m_rot;
        repeat (4 * c_dwell + 4) @(negedge clk);
        #1;
        check("rotations_seen", 32'(m_rot - base), 32'd4);
        check("field_after_wrap", 32'(display_field), 32'h0);
        check("value_after_wrap", 32'(display_value), 32'h00D2);
        check("frame_valid_held", 32'(frame_valid), 32'h1);

        // Constant mismatch, then preamble mismatch: errors, buffer untouched.
        err_q.push_back(1);
        send_frame(192, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_9999, 16'h1111, 16'h2222, 8'h33);
        drain(40, "bad_constant");
        err_q.push_back(2);
        send_frame(192, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_8888, 16'h4444, 16'h5555, 8'h66);
        drain(40, "bad_preamble");

        // Silence after 100 bits times out.
        err_q.push_back(3);
        send_frame(100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_7777, 16'h7777, 16'h7777, 8'h77);
        drain(60, "timeout");
        @(negedge clk);
        check("busy_after_timeout", 32'(busy), 32'h0);
        check("count_after_timeout", 32'(error_count), 32'd3);

        // Restart after 50 bits, then a full good frame commits exactly once.
        f[0] = 16'h0333; f[1] = 16'h0444; f[2] = 16'h005A; f[3] = 16'hBEEF;
        send_frame(50, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_BEEF, 16'h0333, 16'h0444, 8'h5A);
        commit_q.push_back(f);
        send_frame(192, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_BEEF, 16'h0333, 16'h0444, 8'h5A);
        drain(40, "commit2");
        repeat (2 * c_dwell + 2) @(negedge clk);
        #1;
        check("count_after_restart", 32'(error_count), 32'd3);

        // Reset mid-frame discards everything and raises no error.
        send_frame(120, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_1111, 16'h0999, 16'h0888, 8'h01);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("midframe_reset");
        #1;
        reset = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        check("idle_after_reset_busy", 32'(busy), 32'h0);
        check("idle_after_reset_count", 32'(error_count), 32'h0);

        // Error counter saturates at 255 over 256 timed-out frames.
        for (int i = 1; i <= 256; i++) begin
            err_q.push_back((i > 255) ? 255 : i);
            send_frame(1, 32'h0, 32'h0, 32'h0, 16'h0, 16'h0, 8'h0);
            drain(60, "saturate");
        end
        @(negedge clk);
        check("error_count_saturated", 32'(error_count), 32'd255);
        check("no_frame_after_errors", 32'(frame_valid), 32'h0);

        check("leftover_commits", 32'(commit_q.size()), 32'd0);
        check("leftover_errors", 32'(err_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
